wb_queue: RTL and testbench

WB_QUEUE -- requirements
Module: wb_queue

---
 rtl/wb_pkg.sv | 14 +
 rtl/wb_fwd_match.sv | 38 +++
 rtl/wb_queue.sv | 101 ++++++++++
 tb/tb_wb_queue.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared defaults and entry layout for the write-back queue.
// The entry struct describes the default configuration; the queue itself is width-parameterized.
package wb_pkg;

   localparam int N_DEFAULT     = 16;
   localparam int R_DEFAULT     = 3;
   localparam int DEPTH_DEFAULT = 4;

   typedef struct packed {
      logic [R_DEFAULT-1:0] addr;
      logic [N_DEFAULT-1:0] data;
   } wb_entry_t;

endpackage

// File: rtl/wb_fwd_match.sv
// Youngest-match search over the occupied queue entries for one register-file read port.
// Entries are walked from oldest to youngest so the last hit wins.
module wb_fwd_match
   import wb_pkg::*;
#(
   parameter int N     = N_DEFAULT,
   parameter int R     = R_DEFAULT,
   parameter int DEPTH = DEPTH_DEFAULT
) (
   input  logic [R-1:0]             addrs [DEPTH],
   input  logic [N-1:0]             datas [DEPTH],
   input  logic [$clog2(DEPTH)-1:0] head,
   input  logic [$clog2(DEPTH):0]   count,
   input  logic [R-1:0]             ra,
   output logic                     hit,
   output logic [N-1:0]             data
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [PW-1:0] idx;

   // Age offset i maps onto slot head+i; only offsets below count hold live entries.
   always_comb begin
      hit  = 1'b0;
      data = '0;
      idx  = '0;
      for (int i = 0; i < DEPTH; i++) begin
         idx = head + PW'(i);
         if ((CW'(i) < count) && (addrs[idx] == ra)) begin
            hit  = 1'b1;
            data = datas[idx];
         end
      end
   end

endmodule

// File: rtl/wb_queue.sv
// Write-back queue: buffers results ahead of the register-file write port and
// forwards the youngest pending value for each read address.
module wb_queue
   import wb_pkg::*;
#(
   parameter int N     = N_DEFAULT,
   parameter int R     = R_DEFAULT,
   parameter int DEPTH = DEPTH_DEFAULT
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [R-1:0]           in_addr,
   input  logic [N-1:0]           in_data,
   input  logic                   stall,
   output logic                   we3,
   output logic [R-1:0]           wa3,
   output logic [N-1:0]           wd3,
   input  logic [R-1:0]           ra1,
   input  logic [R-1:0]           ra2,
   output logic                   fwd1_hit,
   output logic                   fwd2_hit,
   output logic [N-1:0]           fwd1_data,
   output logic [N-1:0]           fwd2_data,
   output logic [$clog2(DEPTH):0] count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [R-1:0]  addr_mem [DEPTH];
   logic [N-1:0]  data_mem [DEPTH];
   logic [PW-1:0] head;
   logic [PW-1:0] tail;
   logic [CW-1:0] occ;
   logic          empty;
   logic          push;
   logic          retire;

   // in_ready depends only on the occupancy register, so a full queue frees
   // space one cycle after the retire rather than accepting in the same cycle.
   assign empty    = (occ == '0);
   assign in_ready = (occ != FULL);
   assign push     = in_valid && in_ready;
   assign retire   = !rst && !empty && !stall;
   assign count    = occ;

   assign we3 = retire;
   assign wa3 = empty ? '0 : addr_mem[head];
   assign wd3 = empty ? '0 : data_mem[head];

   // Pointer and occupancy bookkeeping; reset discards every pending entry.
   always_ff @(posedge clk) begin
      if (rst) begin
         head <= '0;
         tail <= '0;
         occ  <= '0;
      end else begin
         if (push)
            tail <= tail + 1'b1;
         if (retire)
            head <= head + 1'b1;
         case ({push, retire})
            2'b10:   occ <= occ + CW'(1);
            2'b01:   occ <= occ - CW'(1);
            default: occ <= occ;
         endcase
      end
   end

   // Entry storage is not reset; occupancy alone decides which slots are live.
   always_ff @(posedge clk) begin
      if (push && !rst) begin
         addr_mem[tail] <= in_addr;
         data_mem[tail] <= in_data;
      end
   end

   wb_fwd_match #(.N(N), .R(R), .DEPTH(DEPTH)) u_fwd1 (
      .addrs (addr_mem),
      .datas (data_mem),
      .head  (head),
      .count (occ),
      .ra    (ra1),
      .hit   (fwd1_hit),
      .data  (fwd1_data)
   );

   wb_fwd_match #(.N(N), .R(R), .DEPTH(DEPTH)) u_fwd2 (
      .addrs (addr_mem),
      .datas (data_mem),
      .head  (head),
      .count (occ),
      .ra    (ra2),
      .hit   (fwd2_hit),
      .data  (fwd2_data)
   );

endmodule

// File: tb/tb_wb_queue.sv
// Self-checking bench for wb_queue: directed scenarios followed by random traffic,
// all compared against a queue-based reference model.
module tb_wb_queue;

   localparam int N     = 16;
   localparam int R     = 3;
   localparam int DEPTH = 4;

   typedef struct {
      logic [R-1:0] addr;
      logic [N-1:0] data;
   } ent_t;

   logic         clk;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [R-1:0] in_addr;
   logic [N-1:0] in_data;
   logic         stall;
   logic         we3;
   logic [R-1:0] wa3;
   logic [N-1:0] wd3;
   logic [R-1:0] ra1;
   logic [R-1:0] ra2;
   logic         fwd1_hit;
   logic         fwd2_hit;
   logic [N-1:0] fwd1_data;
   logic [N-1:0] fwd2_data;
   logic [2:0]   count;

   int checks = 0;
   int errors = 0;

   ent_t model_q [$];
   ent_t pushed_log [$];
   ent_t retired_log [$];

   wb_queue #(.N(N), .R(R), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_addr   (in_addr),
      .in_data   (in_data),
      .stall     (stall),
      .we3       (we3),
      .wa3       (wa3),
      .wd3       (wd3),
      .ra1       (ra1),
      .ra2       (ra2),
      .fwd1_hit  (fwd1_hit),
      .fwd2_hit  (fwd2_hit),
      .fwd1_data (fwd1_data),
      .fwd2_data (fwd2_data),
      .count     (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic v, input logic [R-1:0] a, input logic [N-1:0] d,
                                input logic st, input logic [R-1:0] r1, input logic [R-1:0] r2,
                                input logic rs);
      @(negedge clk);
      in_valid = v;
      in_addr  = a;
      in_data  = d;
      stall    = st;
      ra1      = r1;
      ra2      = r2;
      rst      = rs;
      #1;
   endtask

   // Expected outputs come from the model queue (index 0 = oldest), then the
   // model advances by the same rules the coming rising edge should apply.
   task automatic checkOutput();
      logic         e_we;
      logic [R-1:0] e_wa;
      logic [N-1:0] e_wd;
      logic         h1, h2;
      logic [N-1:0] d1, d2;
      logic         do_push, do_ret;
      ent_t         e;
      int           sz;
      sz   = model_q.size();
      e_we = !rst && (sz != 0) && !stall;
      e_wa = (sz != 0) ? model_q[0].addr : '0;
      e_wd = (sz != 0) ? model_q[0].data : '0;
      h1 = 1'b0; d1 = '0; h2 = 1'b0; d2 = '0;
      for (int i = sz - 1; i >= 0; i--) begin
         if (!h1 && model_q[i].addr == ra1) begin h1 = 1'b1; d1 = model_q[i].data; end
         if (!h2 && model_q[i].addr == ra2) begin h2 = 1'b1; d2 = model_q[i].data; end
      end
      chk("count",     32'(count),     32'(sz));
      chk("in_ready",  32'(in_ready),  32'(sz != DEPTH));
      chk("we3",       32'(we3),       32'(e_we));
      chk("wa3",       32'(wa3),       32'(e_wa));
      chk("wd3",       32'(wd3),       32'(e_wd));
      chk("fwd1_hit",  32'(fwd1_hit),  32'(h1));
      chk("fwd1_data", 32'(fwd1_data), 32'(d1));
      chk("fwd2_hit",  32'(fwd2_hit),  32'(h2));
      chk("fwd2_data", 32'(fwd2_data), 32'(d2));
      if (we3 === 1'b1) begin
         e.addr = wa3;
         e.data = wd3;
         retired_log.push_back(e);
      end
      if (rst) begin
         model_q.delete();
      end else begin
         do_push = in_valid && (sz < DEPTH);
         do_ret  = (sz != 0) && !stall;
         if (do_ret)
            void'(model_q.pop_front());
         if (do_push) begin
            e.addr = in_addr;
            e.data = in_data;
            model_q.push_back(e);
            pushed_log.push_back(e);
         end
      end
   endtask

   task automatic step(input logic v, input logic [R-1:0] a, input logic [N-1:0] d,
                       input logic st, input logic [R-1:0] r1, input logic [R-1:0] r2,
                       input logic rs);
      applyStimulus(v, a, d, st, r1, r2, rs);
      checkOutput();
   endtask

   initial begin
      int guard;
      rst = 1'b1; in_valid = 1'b0; in_addr = '0; in_data = '0;
      stall = 1'b0; ra1 = '0; ra2 = '0;
      repeat (2) @(posedge clk);

      // Reset state, then single push with one-cycle latency to we3
      step(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd0, 1'b1);
      step(1'b1, 3'd2, 16'd15,   1'b0, 3'd2, 3'd0, 1'b0);
      step(1'b0, 3'd0, 16'h0000, 1'b0, 3'd2, 3'd0, 1'b0);
      chk("single_retire_addr", 32'(wa3), 32'd2);
      step(1'b0, 3'd0, 16'h0000, 1'b0, 3'd2, 3'd0, 1'b0);

      // Fill under stall, fifth offer ignored, then in-order drain
      for (int i = 1; i <= 4; i++)
         step(1'b1, 3'(i), 16'(i * 16'h0011), 1'b1, 3'd3, 3'd1, 1'b0);
      step(1'b1, 3'd5, 16'h0055, 1'b1, 3'd4, 3'd5, 1'b0);
      chk("full_ready", 32'(in_ready), 32'd0);
      for (int i = 0; i < 5; i++)
         step(1'b0, 3'd0, 16'h0000, 1'b0, 3'd4, 3'd5, 1'b0);

      // Youngest duplicate wins the forwarding search
      step(1'b1, 3'd3, 16'hAAAA, 1'b1, 3'd3, 3'd5, 1'b0);
      step(1'b1, 3'd3, 16'hBBBB, 1'b1, 3'd3, 3'd5, 1'b0);
      step(1'b0, 3'd0, 16'h0000, 1'b1, 3'd3, 3'd5, 1'b0);
      chk("dup_fwd_data", 32'(fwd1_data), 32'hBBBB);
      for (int i = 0; i < 3; i++)
         step(1'b0, 3'd0, 16'h0000, 1'b0, 3'd3, 3'd5, 1'b0);

      // Continuous pushing across pointer wrap: retired order equals pushed order
      pushed_log.delete();
      retired_log.delete();
      guard = 0;
      while (pushed_log.size() < 12 && guard < 60) begin
         step(1'b1, 3'($urandom_range(0, 7)), 16'($urandom), (pushed_log.size() < 4) ? 1'b1 : 1'b0,
              3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 1'b0);
         guard++;
      end
      chk("wrap_push_budget", 32'(pushed_log.size()), 32'd12);
      for (int i = 0; i < 6; i++)
         step(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd1, 1'b0);
      chk("wrap_retired_len", 32'(retired_log.size()), 32'(pushed_log.size()));
      for (int i = 0; i < 12 && i < retired_log.size(); i++) begin
         chk("wrap_order_addr", 32'(retired_log[i].addr), 32'(pushed_log[i].addr));
         chk("wrap_order_data", 32'(retired_log[i].data), 32'(pushed_log[i].data));
      end

      // Reset mid-operation with an offer pending
      for (int i = 0; i < 3; i++)
         step(1'b1, 3'(i + 1), 16'(16'h0100 + i), 1'b1, 3'd1, 3'd2, 1'b0);
      retired_log.delete();
      step(1'b1, 3'd6, 16'h0666, 1'b0, 3'd1, 3'd6, 1'b1);
      step(1'b0, 3'd0, 16'h0000, 1'b0, 3'd1, 3'd6, 1'b0);
      chk("reset_no_retire", 32'(retired_log.size()), 32'd0);

      // Head being retired is still a forwarding source in its last cycle
      step(1'b1, 3'd6, 16'h1234, 1'b1, 3'd6, 3'd0, 1'b0);
      step(1'b0, 3'd0, 16'h0000, 1'b0, 3'd6, 3'd0, 1'b0);
      chk("head_fwd_retiring", 32'(fwd1_hit), 32'd1);
      step(1'b0, 3'd0, 16'h0000, 1'b0, 3'd6, 3'd0, 1'b0);
      chk("head_fwd_after", 32'(fwd1_hit), 32'd0);

      // Random traffic with occasional resets
      for (int i = 0; i < 300; i++)
         step(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), 16'($urandom),
              ($urandom_range(0, 2) == 0), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
              ($urandom_range(0, 59) == 0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
